result_frame_tx: RTL and testbench
==================================

// Module: result_frame_tx
// PURPOSE
//  Host-bound counterpart of the miner's rx_data/data_ready input path.
//  Captures the miner result (tx_data, strobed by send_data) and serializes it as a byte frame over
//  a valid/ready byte stream toward the UART/USB link.
//  Frame = SOF byte, 36 payload bytes MSB-first (nonce then hash), XOR checksum byte.
//  Sits between miner.tx_data/send_data and the link transmitter.
// PARAMETERS
//  PAYLOAD_BYTES  36     payload length in bytes (payload width = 8*PAYLOAD_BYTES = 288)
//  SOF_BYTE       8'hA5  start-of-frame marker
// PORTS
//  clk          in   1    system clock, all logic on posedge
//  n_rst        in   1    asynchronous, active-low reset
//  send_data    in   1    one-cycle strobe: tx_data holds a valid result this cycle
//  tx_data      in   288  miner result {nonce[31:0], hash[255:0]}
//  tx_ready     in   1    link can accept tx_byte this cycle
//  tx_byte      out  8    current frame byte
//  tx_valid     out  1    tx_byte valid
//  busy         out  1    frame in progress or pending result held
//  overrun      out  1    one-cycle pulse: result dropped (both slots occupied)
// BEHAVIOUR
//  Reset: state=IDLE; tx_byte=0, tx_valid=0, busy=0, overrun=0; shift reg, pending reg, checksum,
//   byte counter and pend_vld all cleared. Reset mid-frame aborts the frame immediately; no resume.
//  Transfer rule: a byte moves when tx_valid && tx_ready at posedge.
//   While tx_valid && !tx_ready, tx_byte and tx_valid hold stable.
//   tx_valid never drops without a transfer.
//  FSM IDLE -> SOF -> PAYLOAD -> CSUM -> (IDLE | SOF)
//   IDLE: send_data seen at posedge k -> load shift reg, clear csum -> SOF; tx_valid=1 from cycle k+1.
//   SOF: tx_byte=SOF_BYTE; on transfer -> PAYLOAD, byte counter=0.
//   PAYLOAD: tx_byte=shift[287:280]. On transfer: csum ^= byte, shift <<= 8, counter++.
//    After transfer of byte PAYLOAD_BYTES-1 -> CSUM.
//   CSUM: tx_byte = csum (XOR of all 36 payload bytes; SOF excluded). On transfer:
//    if pend_vld: load shift from pending, clear pend_vld and csum -> SOF (no idle gap)
//    else -> IDLE.
//  Buffering: one pending slot.
//   send_data while state!=IDLE and !pend_vld -> capture into pending, pend_vld=1.
//   send_data while state!=IDLE and pend_vld -> result discarded, overrun=1 next cycle, state unchanged.
//   send_data in CSUM on the same edge as the final transfer with pend_vld=0:
//    the new result is captured; the FSM goes directly to SOF.
//  busy = (state!=IDLE) || pend_vld; registered, same timing as tx_valid.
//  Minimum frame time = 38 cycles with tx_ready held high; latency send_data->first byte = 1 cycle.
//  Counter: 6 bits, compared to PAYLOAD_BYTES-1; no wrap beyond it.
// STRUCTURE
//  miner_pkg: PAYLOAD_W=288, NONCE_W=32, HASH_W=256, SOF default, typedef enum logic[1:0]
//   {IDLE,SOF,PAYLOAD,CSUM} frame_state_t (shared with the future rx framer).
//  No sub-module: FSM, shift reg, pending reg and checksum in one always_ff plus next-state always_comb.
// TESTING (tb_result_frame_tx, CLK_PERIOD=10)
//  1 Reset: n_rst=0 mid-frame -> tx_valid=0, busy=0, tx_byte=00 immediately (asynchronous); after
//    release, idle until send_data.
//  2 Single frame, tx_ready=1: tx_data={32'h42A14695,256'h...01}, send_data 1 cycle ->
//    bytes A5,42,A1,46,95,00x31,01,31 on 38 consecutive cycles; busy drops after last.
//  3 Backpressure: same frame with tx_ready toggling 1,0,0,1... -> identical byte sequence, tx_byte
//    stable during every stall; no byte dropped or duplicated.
//  4 Pending: second send_data (tx_data all-zero) during PAYLOAD -> first frame completes, SOF of second
//    frame follows CSUM with no gap; second frame = A5, 36x00, 00.
//  5 Overrun: third send_data while pend_vld=1 -> overrun pulses exactly 1 cycle; only the two earlier
//    frames are emitted.
//  6 Boundary: send_data on the same edge as the CSUM transfer with pend_vld=0 -> next cycle SOF of
//    the new frame; overrun stays 0.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared miner framing definitions.
//  PAYLOAD_W      result width {nonce, hash}
//  NONCE_W/HASH_W field widths inside the result
//  SOF_DEFAULT    default start-of-frame marker
//  frame_state_t  framer state encoding, also used by the rx framer
package miner_pkg;
  localparam int NONCE_W     = 32;
  localparam int HASH_W      = 256;
  localparam int PAYLOAD_W   = NONCE_W + HASH_W;
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SOF     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } frame_state_t;
endpackage

// File: rtl/result_frame_tx.sv
// Serializes miner results into byte frames: SOF, payload MSB-first, XOR checksum.
// One pending slot buffers a result that arrives while a frame is in flight.
// Ports:
//  clk, n_rst          clock, async active-low reset
//  send_data, tx_data  one-cycle strobe with the result to send
//  tx_ready            link accepts tx_byte this cycle
//  tx_byte, tx_valid   outgoing byte stream (registered)
//  busy                frame in progress or result pending (registered)
//  overrun             one-cycle pulse when a result is dropped
module result_frame_tx
  import miner_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 36,
  parameter logic [7:0] SOF_BYTE      = SOF_DEFAULT
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       send_data,
  input  logic [8*PAYLOAD_BYTES-1:0] tx_data,
  input  logic                       tx_ready,
  output logic [7:0]                 tx_byte,
  output logic                       tx_valid,
  output logic                       busy,
  output logic                       overrun
);
  localparam int PW = 8*PAYLOAD_BYTES;
  localparam logic [5:0] LAST = 6'(PAYLOAD_BYTES-1);

  frame_state_t state, state_n;
  logic [PW-1:0] shift, shift_n, pend, pend_n;
  logic          pend_vld, pend_vld_n;
  logic [7:0]    csum, csum_n, byte_n;
  logic [5:0]    cnt, cnt_n;
  logic          ovr_n, xfer, direct_load;

  assign xfer = tx_valid && tx_ready;

  always_comb begin
    state_n     = state;
    shift_n     = shift;
    pend_n      = pend;
    pend_vld_n  = pend_vld;
    csum_n      = csum;
    cnt_n       = cnt;
    ovr_n       = 1'b0;
    direct_load = 1'b0;
    byte_n      = 8'h00;

    case (state)
      IDLE: if (send_data) begin
        shift_n     = tx_data;
        csum_n      = 8'h00;
        state_n     = SOF;
        direct_load = 1'b1;
      end
      SOF: if (xfer) begin
        state_n = PAYLOAD;
        cnt_n   = 6'd0;
      end
      PAYLOAD: if (xfer) begin
        csum_n  = csum ^ shift[PW-1 -: 8];
        shift_n = shift << 8;
        if (cnt == LAST) state_n = CSUM;
        else             cnt_n   = cnt + 6'd1;
      end
      CSUM: if (xfer) begin
        if (pend_vld) begin
          shift_n    = pend;
          pend_vld_n = 1'b0;
          csum_n     = 8'h00;
          state_n    = SOF;
        end else if (send_data) begin
          // Result arriving on the final edge starts the next frame directly.
          shift_n     = tx_data;
          csum_n      = 8'h00;
          state_n     = SOF;
          direct_load = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Results arriving mid-frame go to the pending slot or are dropped.
    if (send_data && !direct_load) begin
      if (!pend_vld) begin
        pend_n     = tx_data;
        pend_vld_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end

    // Output byte is registered from the next-state view so it is stable during stalls.
    case (state_n)
      SOF:     byte_n = SOF_BYTE;
      PAYLOAD: byte_n = shift_n[PW-1 -: 8];
      CSUM:    byte_n = csum_n;
      default: byte_n = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      shift    <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      csum     <= 8'h00;
      cnt      <= 6'd0;
      tx_byte  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      pend     <= pend_n;
      pend_vld <= pend_vld_n;
      csum     <= csum_n;
      cnt      <= cnt_n;
      tx_byte  <= byte_n;
      tx_valid <= (state_n != IDLE);
      busy     <= (state_n != IDLE) || pend_vld_n;
      overrun  <= ovr_n;
    end
  end
endmodule

// File: tb/tb_result_frame_tx.sv
module tb_result_frame_tx;
  localparam int CLK_PERIOD = 10;
  localparam int PB = 36;
  localparam int FLEN = PB + 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          send_data;
  logic [287:0]  tx_data;
  logic          tx_ready;
  logic [7:0]    tx_byte;
  logic          tx_valid, busy, overrun;

  result_frame_tx dut (
    .clk(clk), .n_rst(n_rst), .send_data(send_data), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .busy(busy), .overrun(overrun)
  );

  always #(CLK_PERIOD/2) clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int ovr_cnt = 0;

  // Model: queue of expected bytes plus count of accepted but unfinished frames.
  logic [7:0] exp_q[$];
  int         n_frames = 0;
  int         pos = 0;
  logic       ovr_m = 1'b0;

  // Transfer log taken from the link side.
  logic [7:0] log_b[$];
  int         log_t[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic push_frame(input logic [287:0] d);
    logic [7:0] b, cs;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < PB; i++) begin
      b = d[287-8*i -: 8];
      cs ^= b;
      exp_q.push_back(b);
    end
    exp_q.push_back(cs);
  endtask

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      exp_q.delete();
      n_frames = 0;
      pos = 0;
      ovr_m = 1'b0;
    end else begin
      logic vld_before;
      cyc++;
      vld_before = exp_q.size() > 0;
      ovr_m = 1'b0;
      if (send_data) begin
        if (n_frames < 2) begin
          push_frame(tx_data);
          n_frames++;
        end else ovr_m = 1'b1;
      end
      if (vld_before && tx_ready) begin
        void'(exp_q.pop_front());
        pos++;
        if (pos == FLEN) begin
          pos = 0;
          n_frames--;
        end
      end
      if (tx_valid && tx_ready) begin
        log_b.push_back(tx_byte);
        log_t.push_back(cyc);
      end
      if (overrun) ovr_cnt++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (n_rst) begin
      chk("tx_valid", int'(tx_valid), int'(exp_q.size() > 0));
      chk("busy", int'(busy), int'(n_frames > 0));
      chk("overrun", int'(overrun), int'(ovr_m));
      if (exp_q.size() > 0) chk("tx_byte", int'(tx_byte), int'(exp_q[0]));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [287:0] d);
    tx_data = d;
    send_data = 1'b1;
    step();
    send_data = 1'b0;
  endtask

  task automatic clear_log();
    log_b.delete();
    log_t.delete();
    ovr_cnt = 0;
  endtask

  localparam logic [287:0] D1 = {32'h42A14695, 256'h01};
  localparam logic [287:0] DZ = '0;
  localparam logic [287:0] DF = '1;

  initial begin
    n_rst = 1'b0;
    send_data = 1'b0;
    tx_data = '0;
    tx_ready = 1'b1;
    step(3);
    n_rst = 1'b1;
    step(2);

    // 1: asynchronous reset mid-frame
    send(D1);
    step(10);
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_valid", int'(tx_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_byte", int'(tx_byte), 0);
    chk("rst_ovr", int'(overrun), 0);
    step(2);
    n_rst = 1'b1;
    step(3);
    chk("idle_valid", int'(tx_valid), 0);
    chk("idle_busy", int'(busy), 0);

    // 2: single frame at full rate
    clear_log();
    send(D1);
    step(FLEN + 4);
    chk("f1_len", log_b.size(), FLEN);
    if (log_b.size() == FLEN) begin
      chk("f1_sof", int'(log_b[0]), 8'hA5);
      chk("f1_b1", int'(log_b[1]), 8'h42);
      chk("f1_b2", int'(log_b[2]), 8'hA1);
      chk("f1_b3", int'(log_b[3]), 8'h46);
      chk("f1_b4", int'(log_b[4]), 8'h95);
      chk("f1_b20", int'(log_b[20]), 8'h00);
      chk("f1_last", int'(log_b[36]), 8'h01);
      chk("f1_csum", int'(log_b[37]), 8'h31);
      chk("f1_span", log_t[37] - log_t[0], FLEN - 1);
    end
    chk("f1_busy", int'(busy), 0);

    // 3: backpressure, ready pattern 1,0,0
    clear_log();
    send(D1);
    for (int i = 0; i < 200 && (busy || i == 0); i++) begin
      tx_ready = (i % 3 == 2);
      step();
    end
    tx_ready = 1'b1;
    step(2);
    chk("bp_len", log_b.size(), FLEN);
    if (log_b.size() == FLEN) begin
      chk("bp_sof", int'(log_b[0]), 8'hA5);
      chk("bp_b1", int'(log_b[1]), 8'h42);
      chk("bp_last", int'(log_b[36]), 8'h01);
      chk("bp_csum", int'(log_b[37]), 8'h31);
    end

    // 4+5: pending frame, then overrun while pending is held
    clear_log();
    send(D1);
    step(10);
    send(DZ);
    step(3);
    send(DF);
    step(2 * FLEN + 10);
    chk("pend_len", log_b.size(), 2 * FLEN);
    chk("ovr_pulses", ovr_cnt, 1);
    if (log_b.size() == 2 * FLEN) begin
      chk("pend_csum1", int'(log_b[37]), 8'h31);
      chk("pend_sof2", int'(log_b[38]), 8'hA5);
      chk("pend_gap", log_t[38] - log_t[37], 1);
      chk("pend_b2", int'(log_b[50]), 8'h00);
      chk("pend_csum2", int'(log_b[75]), 8'h00);
    end

    // 6: new result on the edge of the final CSUM transfer
    clear_log();
    send(D1);
    step(FLEN - 1);
    send(DZ);
    chk("bnd_valid", int'(tx_valid), 1);
    chk("bnd_byte", int'(tx_byte), 8'hA5);
    chk("bnd_ovr", int'(overrun), 0);
    step(FLEN + 5);
    chk("bnd_len", log_b.size(), 2 * FLEN);
    chk("bnd_ovr_cnt", ovr_cnt, 0);
    if (log_b.size() == 2 * FLEN) chk("bnd_gap", log_t[38] - log_t[37], 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
